// File: rtl/timer_gen_if.sv
// Control, status and capture bundle for timer_gen.
// The timer itself uses the slave view; whoever programs it uses the master view.
interface timer_gen_if #(
    parameter int CNT_W   = 32,
    parameter int PRE_W   = 8,
    parameter int TICK_W  = 20,
    parameter int NUM_CAP = 4
);
    logic                       clr;
    logic                       ena;
    logic                       one_shot;
    logic [PRE_W-1:0]           pre_div;
    logic [TICK_W-1:0]          tick_period;
    logic [NUM_CAP-1:0]         cap_evt;
    logic [NUM_CAP-1:0]         cap_ack;
    logic [CNT_W-1:0]           count;
    logic                       pulse_full;
    logic                       pulse_tick;
    logic                       done;
    logic [NUM_CAP*CNT_W-1:0]   cap_val;
    logic [NUM_CAP-1:0]         cap_vld;
    logic [NUM_CAP-1:0]         cap_ovr;

    modport master (
        output clr, ena, one_shot, pre_div, tick_period, cap_evt, cap_ack,
        input  count, pulse_full, pulse_tick, done, cap_val, cap_vld, cap_ovr
    );

    modport slave (
        input  clr, ena, one_shot, pre_div, tick_period, cap_evt, cap_ack,
        output count, pulse_full, pulse_tick, done, cap_val, cap_vld, cap_ovr
    );
endinterface

// File: rtl/timer_gen.sv
// Prescaled timebase with periodic/one-shot main counter, tick strobe and
// per-channel timestamp capture with valid/ack/overrun handshake.
module timer_gen #(
    parameter int CNT_W   = 32,
    parameter int PRE_W   = 8,
    parameter int TICK_W  = 20,
    parameter int NUM_CAP = 4
) (
    input  logic        clk,
    input  logic        rst,
    timer_gen_if.slave  bus
);
    logic [PRE_W-1:0]          pre_cnt;
    logic [TICK_W-1:0]         tick_cnt;
    logic [CNT_W-1:0]          count_p1;
    logic                      done_p1;
    logic                      full_p1;
    logic                      tick_p1;
    logic [NUM_CAP-1:0]        evt_d;
    logic [NUM_CAP-1:0]        evt_edge;
    logic [NUM_CAP*CNT_W-1:0]  cap_val_p1;
    logic [NUM_CAP-1:0]        cap_vld_p1;
    logic [NUM_CAP-1:0]        cap_ovr_p1;
    logic                      step;
    logic                      adv;
    logic                      at_max;

    // >= rather than == so that lowering pre_div/tick_period mid-run never strands the counters
    assign step     = bus.ena & (pre_cnt >= bus.pre_div);
    assign adv      = step & ~(bus.one_shot & done_p1);
    assign at_max   = (count_p1 == {CNT_W{1'b1}});
    assign evt_edge = bus.cap_evt & ~evt_d;

    // Stage p1: prescaler, main counter, tick counter and their strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt  <= '0;
            tick_cnt <= '0;
            count_p1 <= '0;
            done_p1  <= 1'b0;
            full_p1  <= 1'b0;
            tick_p1  <= 1'b0;
        end else if (bus.clr) begin
            pre_cnt  <= '0;
            tick_cnt <= '0;
            count_p1 <= '0;
            done_p1  <= 1'b0;
            full_p1  <= 1'b0;
            tick_p1  <= 1'b0;
        end else begin
            full_p1 <= 1'b0;
            tick_p1 <= 1'b0;
            if (bus.ena) begin
                pre_cnt <= step ? '0 : pre_cnt + 1'b1;
            end
            if (adv) begin
                if (at_max) begin
                    full_p1 <= 1'b1;
                    if (bus.one_shot) begin
                        done_p1 <= 1'b1;
                    end else begin
                        count_p1 <= '0;
                    end
                end else begin
                    count_p1 <= count_p1 + 1'b1;
                end
                if (tick_cnt >= bus.tick_period) begin
                    tick_cnt <= '0;
                    tick_p1  <= 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end
        end
    end

    // Stage p1: capture; takes the count held during the sample cycle, independent of clr/ena
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_d      <= '0;
            cap_val_p1 <= '0;
            cap_vld_p1 <= '0;
            cap_ovr_p1 <= '0;
        end else begin
            evt_d <= bus.cap_evt;
            for (int i = 0; i < NUM_CAP; i++) begin
                if (evt_edge[i]) begin
                    if (!cap_vld_p1[i] || bus.cap_ack[i]) begin
                        cap_val_p1[i*CNT_W +: CNT_W] <= count_p1;
                        cap_vld_p1[i]                <= 1'b1;
                        cap_ovr_p1[i]                <= 1'b0;
                    end else begin
                        cap_ovr_p1[i] <= 1'b1;
                    end
                end else if (bus.cap_ack[i]) begin
                    cap_vld_p1[i] <= 1'b0;
                    cap_ovr_p1[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.count      = count_p1;
    assign bus.pulse_full = full_p1;
    assign bus.pulse_tick = tick_p1;
    assign bus.done       = done_p1;
    assign bus.cap_val    = cap_val_p1;
    assign bus.cap_vld    = cap_vld_p1;
    assign bus.cap_ovr    = cap_ovr_p1;
endmodule

// File: tb/tb_timer_gen.sv
// Bench for timer_gen (8-bit counter): directed scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle against a behavioural model.
module tb_timer_gen;
    localparam int CW   = 8;
    localparam int NCAP = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic clk;
    logic rst;
    timer_gen_if #(.CNT_W(CW), .PRE_W(8), .TICK_W(20), .NUM_CAP(NCAP)) bus ();

    timer_gen #(.CNT_W(CW), .PRE_W(8), .TICK_W(20), .NUM_CAP(NCAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit fin   = 0;

    // model state
    int m_count = 0, m_pre = 0, m_tick = 0;
    bit m_done = 0, m_pf = 0, m_pt = 0;
    int m_val [NCAP];
    bit m_vld [NCAP];
    bit m_ovr [NCAP];
    bit m_evtd[NCAP];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_count = 0; m_pre = 0; m_tick = 0;
        m_done = 0; m_pf = 0; m_pt = 0;
        for (int i = 0; i < NCAP; i++) begin
            m_val[i] = 0; m_vld[i] = 0; m_ovr[i] = 0; m_evtd[i] = 0;
        end
    endtask

    // One clock of the behaviour described for the timer, using integer bookkeeping.
    task automatic model_step();
        int  old_cnt;
        bit  st;
        old_cnt = m_count;
        for (int i = 0; i < NCAP; i++) begin
            if (bus.cap_evt[i] && !m_evtd[i]) begin
                if (!m_vld[i] || bus.cap_ack[i]) begin
                    m_val[i] = old_cnt; m_vld[i] = 1; m_ovr[i] = 0;
                end else begin
                    m_ovr[i] = 1;
                end
            end else if (bus.cap_ack[i]) begin
                m_vld[i] = 0; m_ovr[i] = 0;
            end
            m_evtd[i] = bus.cap_evt[i];
        end
        if (bus.clr) begin
            m_count = 0; m_pre = 0; m_tick = 0; m_done = 0; m_pf = 0; m_pt = 0;
        end else begin
            m_pf = 0; m_pt = 0; st = 0;
            if (bus.ena) begin
                if (m_pre >= int'(bus.pre_div)) begin st = 1; m_pre = 0; end
                else m_pre = m_pre + 1;
            end
            if (st && !(bus.one_shot && m_done)) begin
                if (m_count == MAXC) begin
                    if (bus.one_shot) m_done = 1;
                    else m_count = 0;
                    m_pf = 1;
                end else begin
                    m_count = m_count + 1;
                end
                if (m_tick >= int'(bus.tick_period)) begin m_tick = 0; m_pt = 1; end
                else m_tick = m_tick + 1;
            end
        end
    endtask

    task automatic compare_all();
        logic [NCAP*CW-1:0] ev;
        for (int i = 0; i < NCAP; i++) ev[i*CW +: CW] = CW'(m_val[i]);
        chk("cmp_count", 64'(bus.count), 64'(m_count));
        chk("cmp_pulse_full", 64'(bus.pulse_full), 64'(m_pf));
        chk("cmp_pulse_tick", 64'(bus.pulse_tick), 64'(m_pt));
        chk("cmp_done", 64'(bus.done), 64'(m_done));
        chk("cmp_cap_val", 64'(bus.cap_val), 64'(ev));
        for (int i = 0; i < NCAP; i++) begin
            chk("cmp_cap_vld", 64'(bus.cap_vld[i]), 64'(m_vld[i]));
            chk("cmp_cap_ovr", 64'(bus.cap_ovr[i]), 64'(m_ovr[i]));
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_count"}, 64'(bus.count), 0);
        chk({nm, "_pf"}, 64'(bus.pulse_full), 0);
        chk({nm, "_pt"}, 64'(bus.pulse_tick), 0);
        chk({nm, "_done"}, 64'(bus.done), 0);
        chk({nm, "_cap_val"}, 64'(bus.cap_val), 0);
        chk({nm, "_cap_vld"}, 64'(bus.cap_vld), 0);
        chk({nm, "_cap_ovr"}, 64'(bus.cap_ovr), 0);
    endtask

    task automatic directed();
        int ticks, first_t, last_t, c;
        // reset state
        #2;
        chk_all_zero("reset");
        cyc();
        rst = 1;
        // wrap
        bus.ena = 1; bus.pre_div = 0; bus.tick_period = 1000;
        for (int k = 0; k < 300 && bus.count != 8'(MAXC); k++) cyc();
        chk("wrap_reach_ff", 64'(bus.count), 64'(MAXC));
        chk("wrap_pf_at_ff", 64'(bus.pulse_full), 0);
        cyc();
        chk("wrap_to_zero", 64'(bus.count), 0);
        chk("wrap_pf_high", 64'(bus.pulse_full), 1);
        cyc();
        chk("wrap_pf_one_cycle", 64'(bus.pulse_full), 0);
        chk("wrap_then_one", 64'(bus.count), 1);
        // prescaler and tick
        bus.clr = 1; bus.pre_div = 3; bus.tick_period = 4;
        cyc();
        bus.clr = 0;
        chk("pre_clr", 64'(bus.count), 0);
        ticks = 0; first_t = 0; last_t = 0;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (k == 4) chk("pre_first_step", 64'(bus.count), 1);
            if (bus.pulse_tick) begin
                ticks++;
                if (first_t == 0) first_t = k;
                last_t = k;
            end
        end
        chk("pre_count40", 64'(bus.count), 10);
        chk("tick_n", 64'(ticks), 2);
        chk("tick_first", 64'(first_t), 20);
        chk("tick_spacing", 64'(last_t - first_t), 20);
        cyc(); cyc(); cyc();
        chk("pre_hold3", 64'(bus.count), 10);
        bus.pre_div = 1;
        cyc();
        chk("pre_reduce_step", 64'(bus.count), 11);
        // one-shot
        bus.clr = 1; bus.one_shot = 1; bus.pre_div = 0; bus.tick_period = 2;
        cyc();
        bus.clr = 0;
        for (int k = 0; k < 300 && bus.count != 8'(MAXC); k++) cyc();
        chk("os_reach_ff", 64'(bus.count), 64'(MAXC));
        chk("os_done_before", 64'(bus.done), 0);
        cyc();
        chk("os_hold", 64'(bus.count), 64'(MAXC));
        chk("os_done", 64'(bus.done), 1);
        chk("os_pf", 64'(bus.pulse_full), 1);
        ticks = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (bus.pulse_tick) ticks++;
        end
        chk("os_no_ticks", 64'(ticks), 0);
        chk("os_still_ff", 64'(bus.count), 64'(MAXC));
        chk("os_pf_gone", 64'(bus.pulse_full), 0);
        bus.clr = 1;
        cyc();
        bus.clr = 0; bus.one_shot = 0;
        chk("os_clr_count", 64'(bus.count), 0);
        chk("os_clr_done", 64'(bus.done), 0);
        // capture and overrun on ch2
        bus.tick_period = 1000;
        for (int k = 0; k < 300 && bus.count != 8'h10; k++) cyc();
        bus.cap_evt = 4'b0100;
        cyc();
        bus.cap_evt = 4'b0000;
        chk("cap2_val", 64'(bus.cap_val[2*CW +: CW]), 64'h10);
        chk("cap2_vld", 64'(bus.cap_vld[2]), 1);
        for (int k = 0; k < 300 && bus.count != 8'h20; k++) cyc();
        bus.cap_evt = 4'b0100;
        cyc();
        bus.cap_evt = 4'b0000;
        chk("cap2_keep", 64'(bus.cap_val[2*CW +: CW]), 64'h10);
        chk("cap2_ovr", 64'(bus.cap_ovr[2]), 1);
        bus.cap_ack = 4'b0100;
        cyc();
        bus.cap_ack = 4'b0000;
        chk("cap2_ack_vld", 64'(bus.cap_vld[2]), 0);
        chk("cap2_ack_ovr", 64'(bus.cap_ovr[2]), 0);
        // edge together with ack on ch0
        bus.cap_evt = 4'b0001;
        cyc();
        bus.cap_evt = 4'b0000;
        cyc();
        c = int'(bus.count);
        bus.cap_evt = 4'b0001; bus.cap_ack = 4'b0001;
        cyc();
        bus.cap_evt = 4'b0000; bus.cap_ack = 4'b0000;
        chk("cap0_ack_val", 64'(bus.cap_val[0 +: CW]), 64'(c));
        chk("cap0_ack_vld", 64'(bus.cap_vld[0]), 1);
        chk("cap0_ack_ovr", 64'(bus.cap_ovr[0]), 0);
        // clr with a step pending
        bus.clr = 1;
        cyc();
        bus.clr = 0;
        chk("clr_step", 64'(bus.count), 0);
        chk("clr_keeps_cap", 64'(bus.cap_vld[0]), 1);
        // ena=0 freezes counter and prescaler
        bus.pre_div = 3; bus.clr = 1;
        cyc();
        bus.clr = 0;
        cyc(); cyc();
        bus.ena = 0;
        for (int k = 0; k < 5; k++) cyc();
        chk("frz_count", 64'(bus.count), 0);
        bus.ena = 1;
        cyc();
        chk("frz_pre3", 64'(bus.count), 0);
        cyc();
        chk("frz_step", 64'(bus.count), 1);
        // asynchronous reset with capture pending, cap_evt[1] held across release
        bus.pre_div = 0;
        for (int k = 0; k < 5; k++) cyc();
        @(posedge clk);
        #3;
        rst = 0;
        bus.cap_evt = 4'b0010;
        #1;
        chk_all_zero("arst");
        cyc(); cyc();
        rst = 1;
        cyc();
        chk("rel_cap1_vld", 64'(bus.cap_vld[1]), 1);
        chk("rel_cap1_val", 64'(bus.cap_val[1*CW +: CW]), 0);
        chk("rel_count", 64'(bus.count), 1);
        bus.cap_evt = 4'b0000;
    endtask

    task automatic random_run();
        for (int k = 0; k < 3000; k++) begin
            cyc();
            bus.clr     = ($urandom_range(0, 49) == 0);
            bus.ena     = ($urandom_range(0, 3) != 0);
            bus.pre_div = 8'($urandom_range(0, 2));
            bus.tick_period = 20'($urandom_range(0, 5));
            bus.cap_evt = 4'($urandom);
            bus.cap_ack = 4'(($urandom_range(0, 7) == 0) ? $urandom : 0);
            if ($urandom_range(0, 299) == 0) bus.one_shot = ~bus.one_shot;
            if (k == 1500) begin
                #2 rst = 0;
                cyc();
                rst = 1;
            end
        end
    endtask

    initial begin
        rst = 0;
        bus.clr = 0; bus.ena = 0; bus.one_shot = 0;
        bus.pre_div = 0; bus.tick_period = 0;
        bus.cap_evt = 0; bus.cap_ack = 0;
        model_reset();
        fork
            begin
                while (!fin) begin
                    @(posedge clk or negedge rst);
                    if (!rst) model_reset();
                    else model_step();
                end
            end
            begin
                while (!fin) begin
                    @(negedge clk);
                    if (!fin) compare_all();
                end
            end
            begin
                directed();
                random_run();
                cyc();
                fin = 1;
            end
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
